// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Holds the FSM state encoding, the RV32I funct3 access codes and the access-size decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unlisted funct3 codes behave as full-word accesses.
  function automatic acc_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data formatting for the LSU: store lane replication and byte strobes,
// load byte/half selection with sign/zero extension, and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ld_data_o,
  output logic        misaligned_o
);

  acc_size_e   size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    size         = size_of(funct3_i);
    wdata_o      = st_data_i;
    wstrb_o      = 4'b1111;
    misaligned_o = 1'b0;

    case (size)
      SZ_B: begin
        wdata_o = {4{st_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      SZ_H: begin
        wdata_o      = {2{st_data_i[15:0]}};
        wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one ready/valid data-memory transaction per
// aligned load/store, stalling the pipeline until the result can enter MEM/WB.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Min_valid,
  input  logic        Min_mem_read,
  input  logic        Min_mem_write,
  input  logic [2:0]  Min_funct3,
  input  logic [31:0] Min_alu_out,
  input  logic [31:0] Min_rs2_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] Mout_alu_out,
  output logic [31:0] Mout_ld_data,
  output logic        mem_err
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             err_q, err_d;

  logic        is_read, is_write, mem_op;
  logic        misaligned;
  logic [31:0] st_wdata, ld_ext;
  logic [3:0]  st_wstrb;
  logic        stall_c;
  logic [31:0] ld_data_c;

  // Read wins when both read and write are flagged.
  assign is_read  = Min_valid & Min_mem_read;
  assign is_write = Min_valid & Min_mem_write & ~Min_mem_read;
  assign mem_op   = is_read | is_write;

  lsu_align u_align (
    .funct3_i     (Min_funct3),
    .addr_lo_i    (Min_alu_out[1:0]),
    .st_data_i    (Min_rs2_data),
    .ld_word_i    (rbuf_q),
    .wdata_o      (st_wdata),
    .wstrb_o      (st_wstrb),
    .ld_data_o    (ld_ext),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rbuf_d    = rbuf_q;
    req_d     = req_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    err_d     = 1'b0;
    stall_c   = 1'b0;
    ld_data_c = '0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_write;
            wstrb_d = is_write ? st_wstrb : 4'b0000;
            cnt_d   = '0;
            rbuf_d  = '0;
          end
        end
      end

      REQ: begin
        stall_c = 1'b1;
        if (dm_ready) begin
          rbuf_d  = is_read ? dm_rdata : '0;
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rbuf_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // MEM/WB captures at the end of this cycle; the instruction is never reissued.
        state_d = IDLE;
        if (is_read) ld_data_c = ld_ext;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
    end
  end

  // Address and write data follow the upstream inputs, which are held while stalled.
  assign dm_req       = req_q;
  assign dm_we        = we_q;
  assign dm_wstrb     = wstrb_q;
  assign dm_addr      = {Min_alu_out[31:2], 2'b00};
  assign dm_wdata     = st_wdata;
  assign stall        = stall_c & ~rst;
  assign Mout_alu_out = Min_alu_out;
  assign Mout_ld_data = ld_data_c;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed corner cases plus randomized
// operations, compared each cycle against a transaction-level timeline model.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        Min_valid, Min_mem_read, Min_mem_write;
  logic [2:0]  Min_funct3;
  logic [31:0] Min_alu_out, Min_rs2_data;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        stall, mem_err;
  logic [31:0] Mout_alu_out, Mout_ld_data;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .Min_valid     (Min_valid),
    .Min_mem_read  (Min_mem_read),
    .Min_mem_write (Min_mem_write),
    .Min_funct3    (Min_funct3),
    .Min_alu_out   (Min_alu_out),
    .Min_rs2_data  (Min_rs2_data),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_wstrb      (dm_wstrb),
    .dm_ready      (dm_ready),
    .dm_rdata      (dm_rdata),
    .stall         (stall),
    .Mout_alu_out  (Mout_alu_out),
    .Mout_ld_data  (Mout_ld_data),
    .mem_err       (mem_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    int          n;
    logic [31:0] v, mask;
    n = size_bytes(f3);
    if (n == 4) return word;
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (word >> (8 * off)) & mask;
    if (f3[2] == 1'b0 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
    int         n;
    logic [3:0] s;
    n = size_bytes(f3);
    s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= int'(off)) && (i < int'(off) + n);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (size_bytes(f3))
      1:       return {4{rs2[7:0]}};
      2:       return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  // ---------------- per-cycle expectations ----------------
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_err, e_ld_chk;
  logic [31:0] e_alu, e_addr, e_wdata, e_ld;
  logic [3:0]  e_wstrb;
  logic        err_carry = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",    32'(stall),   32'(e_stall));
      check("dm_req",   32'(dm_req),  32'(e_req));
      check("mem_err",  32'(mem_err), 32'(e_err));
      check("alu_out",  Mout_alu_out, e_alu);
      if (e_req) begin
        check("dm_addr", dm_addr,     e_addr);
        check("dm_we",   32'(dm_we),  32'(e_we));
        if (e_we) begin
          check("dm_wdata", dm_wdata,        e_wdata);
          check("dm_wstrb", 32'(dm_wstrb),   32'(e_wstrb));
        end
      end
      if (e_ld_chk) check("ld_data", Mout_ld_data, e_ld);
    end
  end

  // Observations for the hand-computed literal checks.
  int          stall_seen, req_seen, err_seen;
  logic [31:0] last_ld, last_alu, last_wdata;
  logic [3:0]  last_wstrb;

  task automatic step();
    @(negedge clk);
    if (stall)   stall_seen++;
    if (mem_err) err_seen++;
    if (dm_req) begin
      req_seen++;
      last_wdata = dm_wdata;
      last_wstrb = dm_wstrb;
    end
    last_ld  = Mout_ld_data;
    last_alu = Mout_alu_out;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_noise();
    dm_ready = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
  endtask

  // Presents one instruction (called at posedge+1) and walks its whole expected timeline.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input int delay,
                        input logic [31:0] word);
    logic is_rd, is_wr, mis, tmo;
    int   nreq;
    is_rd = v & rd;
    is_wr = v & wr & ~rd;
    mis   = (int'(addr[1:0]) % size_bytes(f3)) != 0;
    stall_seen = 0;
    req_seen   = 0;

    Min_valid = v; Min_mem_read = rd; Min_mem_write = wr;
    Min_funct3 = f3; Min_alu_out = addr; Min_rs2_data = rs2;
    e_alu = addr;
    e_req = 1'b0;

    if (!(is_rd || is_wr) || mis) begin
      e_stall = 1'b0; e_ld_chk = 1'b1; e_ld = '0;
      e_err = err_carry;
      err_carry = (is_rd || is_wr) && mis;
      idle_noise();
      step();
    end else begin
      e_stall = 1'b1; e_ld_chk = 1'b0;
      e_err = err_carry; err_carry = 1'b0;
      idle_noise();
      step();

      tmo  = delay >= TIMEOUT;
      nreq = tmo ? TIMEOUT : delay + 1;
      for (int k = 0; k < nreq; k++) begin
        e_stall = 1'b1; e_req = 1'b1; e_we = is_wr; e_err = 1'b0;
        e_addr  = {addr[31:2], 2'b00};
        e_wdata = model_wdata(f3, rs2);
        e_wstrb = model_strb(f3, addr[1:0]);
        dm_ready = (k == delay);
        dm_rdata = (k == delay) ? word : $urandom;
        step();
      end

      e_stall = 1'b0; e_req = 1'b0; e_ld_chk = 1'b1;
      e_ld  = (is_rd && !tmo) ? model_load(word, f3, addr[1:0]) : 32'h0;
      e_err = tmo;
      idle_noise();
      step();
    end
  endtask

  task automatic alu_op(input logic [31:0] val);
    run_op(1'b1, 1'b0, 1'b0, F3_W, val, $urandom, 0, 32'h0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          err_before;
    logic        rd, wr, v;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;

    // Reset with an aligned load present: outputs must stay quiet.
    rst = 1'b1;
    Min_valid = 1'b1; Min_mem_read = 1'b1; Min_mem_write = 1'b0;
    Min_funct3 = F3_W; Min_alu_out = 32'h40; Min_rs2_data = '0;
    dm_ready = 1'b0; dm_rdata = '0;
    #1;
    check("rst_stall",   32'(stall),    32'h0);
    check("rst_dm_req",  32'(dm_req),   32'h0);
    check("rst_dm_we",   32'(dm_we),    32'h0);
    check("rst_dm_wstrb",32'(dm_wstrb), 32'h0);
    check("rst_mem_err", 32'(mem_err),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    Min_valid = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // Plain ALU op.
    alu_op(32'h1234);
    check("alu_lit_out",   last_alu, 32'h1234);
    check("alu_lit_ld",    last_ld, 32'h0);
    check("alu_lit_stall", 32'(stall_seen), 32'd0);
    check("alu_lit_req",   32'(req_seen), 32'd0);

    // LB / LBU at 0x103 with dm_ready on the 4th request cycle.
    run_op(1'b1, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 3, 32'h80FF_0000);
    check("lb_lit_ld",    last_ld, 32'hFFFF_FF80);
    check("lb_lit_stall", 32'(stall_seen), 32'd5);
    run_op(1'b1, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 3, 32'h80FF_0000);
    check("lbu_lit_ld",   last_ld, 32'h0000_0080);

    // SH at 0x202, immediate ready.
    run_op(1'b1, 1'b0, 1'b1, F3_H, 32'h202, 32'hDEAD_BEEF, 0, 32'h0);
    check("sh_lit_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh_lit_wstrb", 32'(last_wstrb), 32'hC);
    check("sh_lit_stall", 32'(stall_seen), 32'd2);
    check("sh_lit_ld",    last_ld, 32'h0);

    // Misaligned LW: no request, no stall, one mem_err pulse on the next cycle.
    err_seen = 0;
    run_op(1'b1, 1'b1, 1'b0, F3_W, 32'h301, 32'h0, 0, 32'h1111_1111);
    check("mis_lit_req",   32'(req_seen), 32'd0);
    check("mis_lit_stall", 32'(stall_seen), 32'd0);
    check("mis_lit_ld",    last_ld, 32'h0);
    alu_op(32'h5);
    alu_op(32'h6);
    check("mis_lit_err", 32'(err_seen), 32'd1);

    // Timeout: dm_ready never comes.
    err_before = err_seen;
    run_op(1'b1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 100000, 32'hFFFF_FFFF);
    check("tmo_lit_req",   32'(req_seen), 32'd256);
    check("tmo_lit_stall", 32'(stall_seen), 32'd257);
    check("tmo_lit_ld",    last_ld, 32'h0);
    check("tmo_lit_err",   32'(err_seen - err_before), 32'd1);
    alu_op(32'h7);

    // Ready on the very last allowed cycle still succeeds.
    err_before = err_seen;
    run_op(1'b1, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
    check("edge_lit_ld",  last_ld, 32'hCAFE_F00D);
    check("edge_lit_err", 32'(err_seen - err_before), 32'd0);

    // Reset during the second wait cycle of a load.
    chk_en = 1'b0;
    Min_valid = 1'b1; Min_mem_read = 1'b1; Min_mem_write = 1'b0;
    Min_funct3 = F3_W; Min_alu_out = 32'h80;
    dm_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_req_before", 32'(dm_req), 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_req",   32'(dm_req),  32'h0);
    check("rstmid_stall", 32'(stall),   32'h0);
    check("rstmid_err",   32'(mem_err), 32'h0);
    Min_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_err_after",   32'(mem_err), 32'h0);
    check("rstmid_stall_after", 32'(stall),   32'h0);
    @(posedge clk); #1;
    err_carry = 1'b0;
    chk_en = 1'b1;
    run_op(1'b1, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1, 32'h1357_9BDF);
    check("rstmid_lw_ld", last_ld, 32'h1357_9BDF);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      v    = ($urandom_range(0, 9) != 0);
      rd   = (kind >= 2 && kind <= 5) || kind == 9;
      wr   = (kind >= 6);
      f3   = (wr && !rd) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_op(v, rd, wr, f3, addr, $urandom, $urandom_range(0, 5), $urandom);
    end

    alu_op(32'h0);
    alu_op(32'h0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
